// File: rtl/trace_pkg.sv
// Shared types and sizing for the pipeline tag tracker.
// Tags follow each instruction slot from decode through writeback.
package trace_pkg;

  localparam int MAX_ID_DEF = 71;
  localparam int ID_W_DEF   = 7;
  localparam int RET_W      = 32;
  localparam int HAZ_W      = 16;
  localparam int CYC_W      = 32;

  typedef struct packed {
    logic                valid;
    logic [ID_W_DEF-1:0] id;
  } tag_t;

endpackage

// File: rtl/pipeline_tracker_if.sv
// Hazard controls in, per-stage tags and statistics out.
// master drives the hazards, slave is the tracker.
interface pipeline_tracker_if
  import trace_pkg::*;
#(
  parameter int ID_W = ID_W_DEF
) ();

  logic             stall;
  logic             flush;
  logic             halt;
  logic             fetch_valid;
  logic [ID_W-1:0]  fetch_id;
  logic             decode_valid;
  logic [ID_W-1:0]  decode_id;
  logic             execute_valid;
  logic [ID_W-1:0]  execute_id;
  logic             memory_valid;
  logic [ID_W-1:0]  memory_id;
  logic             wb_valid;
  logic [ID_W-1:0]  wb_id;
  logic             drained;
  logic [RET_W-1:0] retired_cnt;
  logic [HAZ_W-1:0] stall_cnt;
  logic [HAZ_W-1:0] squash_cnt;
  logic [CYC_W-1:0] cycle_cnt;

  modport master (
    output stall, flush, halt,
    input  fetch_valid, fetch_id,
    input  decode_valid, decode_id,
    input  execute_valid, execute_id,
    input  memory_valid, memory_id,
    input  wb_valid, wb_id,
    input  drained, retired_cnt,
    input  stall_cnt, squash_cnt, cycle_cnt
  );

  modport slave (
    input  stall, flush, halt,
    output fetch_valid, fetch_id,
    output decode_valid, decode_id,
    output execute_valid, execute_id,
    output memory_valid, memory_id,
    output wb_valid, wb_id,
    output drained, retired_cnt,
    output stall_cnt, squash_cnt, cycle_cnt
  );

endinterface

// File: rtl/pipe_tag_reg.sv
// One pipeline tag register with hold and bubble controls.
// Hold wins over bubble; a bubble clears valid but keeps the id.
module pipe_tag_reg
  import trace_pkg::*;
#(
  parameter type tag_T = tag_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  input  logic bubble,
  input  tag_T d,
  output tag_T q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q.valid <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_tracker.sv
// Tracks instruction sequence ids through a 5-stage pipeline.
// Fetch is combinational from next_id; D/E/M/W are tag registers.
module pipeline_tracker
  import trace_pkg::*;
#(
  parameter int MAX_ID = MAX_ID_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  pipeline_tracker_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } stag_t;

  logic [ID_W-1:0]  next_id;
  logic [ID_W-1:0]  id_inc;
  logic             halt_q;
  logic             drained;
  logic             advance;
  logic             squash;
  logic             any_valid;
  logic [RET_W-1:0] retired_cnt;
  logic [HAZ_W-1:0] stall_cnt;
  logic [HAZ_W-1:0] squash_cnt;
  logic [CYC_W-1:0] cycle_cnt;
  stag_t            f_tag;
  stag_t            d_q;
  stag_t            e_q;
  stag_t            m_q;
  stag_t            w_q;

  assign advance   = !halt_q && !bus.stall;
  assign squash    = bus.flush && !bus.stall;
  assign any_valid = d_q.valid | e_q.valid
                   | m_q.valid | w_q.valid;
  assign id_inc    = (next_id == ID_W'(MAX_ID))
                   ? '0 : next_id + ID_W'(1);

  // Flush lands a squashed slot in D; its id is still consumed.
  assign f_tag.valid = !halt_q && !bus.flush;
  assign f_tag.id    = next_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_id     <= '0;
      halt_q      <= 1'b0;
      drained     <= 1'b0;
      retired_cnt <= '0;
      stall_cnt   <= '0;
      squash_cnt  <= '0;
      cycle_cnt   <= '0;
    end else begin
      if (advance) next_id <= id_inc;
      if (bus.halt) halt_q <= 1'b1;
      drained   <= halt_q && !any_valid;
      cycle_cnt <= cycle_cnt + 1'b1;
      if (w_q.valid)
        retired_cnt <= retired_cnt + 1'b1;
      if (bus.stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (squash && squash_cnt != '1)
        squash_cnt <= squash_cnt + 1'b1;
    end
  end

  pipe_tag_reg #(.tag_T(stag_t)) u_d (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (bus.stall),
    .bubble (1'b0),
    .d      (f_tag),
    .q      (d_q)
  );

  pipe_tag_reg #(.tag_T(stag_t)) u_e (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (1'b0),
    .bubble (bus.stall),
    .d      (d_q),
    .q      (e_q)
  );

  pipe_tag_reg #(.tag_T(stag_t)) u_m (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (1'b0),
    .bubble (1'b0),
    .d      (e_q),
    .q      (m_q)
  );

  pipe_tag_reg #(.tag_T(stag_t)) u_w (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (1'b0),
    .bubble (1'b0),
    .d      (m_q),
    .q      (w_q)
  );

  assign bus.fetch_valid   = !halt_q;
  assign bus.fetch_id      = next_id;
  assign bus.decode_valid  = d_q.valid;
  assign bus.decode_id     = d_q.id;
  assign bus.execute_valid = e_q.valid;
  assign bus.execute_id    = e_q.id;
  assign bus.memory_valid  = m_q.valid;
  assign bus.memory_id     = m_q.id;
  assign bus.wb_valid      = w_q.valid;
  assign bus.wb_id         = w_q.id;
  assign bus.drained       = drained;
  assign bus.retired_cnt   = retired_cnt;
  assign bus.stall_cnt     = stall_cnt;
  assign bus.squash_cnt    = squash_cnt;
  assign bus.cycle_cnt     = cycle_cnt;

endmodule

// File: tb/tb_pipeline_tracker.sv
// Bench for pipeline_tracker: scoreboard of issued ids vs writeback.
// Scenario tasks cover reset, stall, flush, wrap and halt/drain.
module tb_pipeline_tracker;
  import trace_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   exp_id = 0;
  bit   halt_m = 1'b0;
  bit   mon_en = 1'b0;
  int   sb[$];
  int   wb_log[$];

  always #5 clk = ~clk;

  pipeline_tracker_if #(.ID_W(7)) bus ();

  pipeline_tracker #(.MAX_ID(71), .ID_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // writeback monitor pops the expected id stream
  always @(negedge clk) begin : mon
    int e;
    if (mon_en && rst_n && bus.wb_valid) begin
      total++;
      wb_log.push_back(int'(bus.wb_id));
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL wb_order: got id %0d, none expected", bus.wb_id);
      end else begin
        e = sb.pop_front();
        if (int'(bus.wb_id) !== e) begin
          bad++;
          $display("FAIL wb_order: got %0d want %0d", bus.wb_id, e);
        end
      end
    end
  end

  task automatic step();
    if (rst_n && !halt_m && !bus.stall) begin
      if (!bus.flush) sb.push_back(exp_id);
      exp_id = (exp_id == 71) ? 0 : exp_id + 1;
    end
    if (rst_n && bus.halt) halt_m = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_enter();
    rst_n = 1'b0;
    mon_en = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.halt = 1'b0;
    step();
    step();
  endtask

  task automatic reset_leave();
    sb.delete();
    wb_log.delete();
    exp_id = 0;
    halt_m = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    reset_enter();
    total++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_id !== 7'd0) begin
      bad++;
      $display("FAIL reset_fetch: got v=%b id=%0d want v=1 id=0",
               bus.fetch_valid, bus.fetch_id);
    end
    total++;
    if ({bus.decode_valid, bus.execute_valid,
         bus.memory_valid, bus.wb_valid, bus.drained} !== 5'b0) begin
      bad++;
      $display("FAIL reset_valids: got %b%b%b%b drained=%b want all 0",
               bus.decode_valid, bus.execute_valid, bus.memory_valid,
               bus.wb_valid, bus.drained);
    end
    total++;
    if ({bus.retired_cnt, bus.stall_cnt, bus.squash_cnt,
         bus.cycle_cnt} !== 96'd0) begin
      bad++;
      $display("FAIL reset_cnts: got ret=%0d st=%0d sq=%0d cyc=%0d want 0",
               bus.retired_cnt, bus.stall_cnt, bus.squash_cnt, bus.cycle_cnt);
    end
    reset_leave();
  endtask

  task automatic test_free_run();
    reset_enter();
    reset_leave();
    for (int i = 0; i < 10; i++) begin
      step();
      if (cyc == 3) begin
        total++;
        if (bus.wb_valid !== 1'b0) begin
          bad++;
          $display("FAIL free_wb_early: got wb_valid=%b want 0 at cycle 3",
                   bus.wb_valid);
        end
      end
      if (cyc == 4) begin
        total++;
        if (bus.wb_valid !== 1'b1 || bus.wb_id !== 7'd0) begin
          bad++;
          $display("FAIL free_wb_first: got v=%b id=%0d want v=1 id=0",
                   bus.wb_valid, bus.wb_id);
        end
      end
    end
    total++;
    if (bus.retired_cnt !== 32'd6 || bus.cycle_cnt !== 32'd10) begin
      bad++;
      $display("FAIL free_cnts: got ret=%0d cyc=%0d want ret=6 cyc=10",
               bus.retired_cnt, bus.cycle_cnt);
    end
    total++;
    if (wb_log.size() != 6 || wb_log[5] != 5) begin
      bad++;
      $display("FAIL free_log: got %0d entries want 6 ending in 5",
               wb_log.size());
    end
  endtask

  task automatic test_stall();
    bit found;
    reset_enter();
    reset_leave();
    repeat (4) step();
    total++;
    if (bus.decode_valid !== 1'b1 || bus.decode_id !== 7'd3) begin
      bad++;
      $display("FAIL stall_pre_d: got v=%b id=%0d want v=1 id=3",
               bus.decode_valid, bus.decode_id);
    end
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (bus.decode_valid !== 1'b1 || bus.decode_id !== 7'd3 ||
          bus.execute_valid !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: got d=%b/%0d e_valid=%b want d=1/3 e_valid=0",
                 bus.decode_valid, bus.decode_id, bus.execute_valid);
      end
    end
    bus.stall = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.wb_valid && bus.wb_id == 7'd3) found = 1'b1;
    end
    total++;
    if (!found || cyc != 9) begin
      bad++;
      $display("FAIL stall_latency: got found=%b cycle=%0d want cycle 9",
               found, cyc);
    end
    total++;
    if (bus.stall_cnt !== 16'd2) begin
      bad++;
      $display("FAIL stall_cnt: got %0d want 2", bus.stall_cnt);
    end
  endtask

  task automatic test_flush();
    bit seen5;
    reset_enter();
    reset_leave();
    repeat (5) step();
    total++;
    if (int'(bus.fetch_id) !== exp_id) begin
      bad++;
      $display("FAIL flush_pre: got fetch_id=%0d want %0d",
               bus.fetch_id, exp_id);
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    total++;
    if (bus.decode_valid !== 1'b0 || bus.decode_id !== 7'd5) begin
      bad++;
      $display("FAIL flush_d: got v=%b id=%0d want v=0 id=5",
               bus.decode_valid, bus.decode_id);
    end
    seen5 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.wb_valid && bus.wb_id == 7'd5) seen5 = 1'b1;
    end
    total++;
    if (seen5 || wb_log.size() < 6 || wb_log[4] != 4 || wb_log[5] != 6) begin
      bad++;
      $display("FAIL flush_seq: got seen5=%b entries=%0d want 4 then 6",
               seen5, wb_log.size());
    end
    total++;
    if (bus.squash_cnt !== 16'd1) begin
      bad++;
      $display("FAIL flush_cnt: got %0d want 1", bus.squash_cnt);
    end
  endtask

  task automatic test_both();
    reset_enter();
    reset_leave();
    repeat (4) step();
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    total++;
    if (bus.decode_valid !== 1'b1 || bus.decode_id !== 7'd3 ||
        bus.execute_valid !== 1'b0) begin
      bad++;
      $display("FAIL both_pipe: got d=%b/%0d e_valid=%b want d=1/3 e_valid=0",
               bus.decode_valid, bus.decode_id, bus.execute_valid);
    end
    total++;
    if (bus.squash_cnt !== 16'd0 || bus.stall_cnt !== 16'd1) begin
      bad++;
      $display("FAIL both_cnts: got sq=%0d st=%0d want sq=0 st=1",
               bus.squash_cnt, bus.stall_cnt);
    end
    repeat (10) step();
    total++;
    if (wb_log.size() < 5 || wb_log[3] != 3 || wb_log[4] != 4) begin
      bad++;
      $display("FAIL both_seq: got entries=%0d want 3 then 4",
               wb_log.size());
    end
  endtask

  task automatic test_wrap();
    int want[4] = '{70, 71, 0, 1};
    reset_enter();
    reset_leave();
    repeat (84) step();
    total++;
    if (bus.retired_cnt !== 32'd80 || wb_log.size() != 80) begin
      bad++;
      $display("FAIL wrap_ret: got ret=%0d log=%0d want 80",
               bus.retired_cnt, wb_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wb_log.size() <= 70 + i || wb_log[70 + i] != want[i]) begin
        bad++;
        $display("FAIL wrap_id: entry %0d got %0d want %0d", 70 + i,
                 (wb_log.size() > 70 + i) ? wb_log[70 + i] : -1, want[i]);
      end
    end
  endtask

  task automatic test_halt_reset();
    reset_enter();
    reset_leave();
    repeat (9) step();
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    total++;
    if (bus.fetch_valid !== 1'b0) begin
      bad++;
      $display("FAIL halt_fetch: got fetch_valid=%b want 0", bus.fetch_valid);
    end
    while (cyc < 20) begin
      step();
      if (cyc == 13) begin
        total++;
        if (bus.wb_valid !== 1'b1 || bus.wb_id !== 7'd9) begin
          bad++;
          $display("FAIL halt_last: got v=%b id=%0d want v=1 id=9",
                   bus.wb_valid, bus.wb_id);
        end
      end
      if (cyc == 14 || cyc == 15) begin
        total++;
        if (bus.drained !== (cyc == 15)) begin
          bad++;
          $display("FAIL halt_drained: cycle %0d got %b want %b",
                   cyc, bus.drained, cyc == 15);
        end
      end
    end
    total++;
    if (sb.size() != 0 || bus.retired_cnt !== 32'd10) begin
      bad++;
      $display("FAIL halt_ret: got pending=%0d ret=%0d want 0 and 10",
               sb.size(), bus.retired_cnt);
    end
    rst_n = 1'b0;
    mon_en = 1'b0;
    step();
    total++;
    if ({bus.retired_cnt, bus.stall_cnt, bus.squash_cnt,
         bus.cycle_cnt} !== 96'd0 || bus.drained !== 1'b0) begin
      bad++;
      $display("FAIL halt_rst_cnts: got ret=%0d cyc=%0d drained=%b want 0",
               bus.retired_cnt, bus.cycle_cnt, bus.drained);
    end
    reset_leave();
    total++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_id !== 7'd0) begin
      bad++;
      $display("FAIL halt_rst_fetch: got v=%b id=%0d want v=1 id=0",
               bus.fetch_valid, bus.fetch_id);
    end
    step();
    total++;
    if (bus.decode_valid !== 1'b1 || bus.decode_id !== 7'd0) begin
      bad++;
      $display("FAIL halt_rst_d: got v=%b id=%0d want v=1 id=0",
               bus.decode_valid, bus.decode_id);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_flush();
    test_both();
    test_wrap();
    test_halt_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
